// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath width, reset PC, bubble encoding and the
// IF/ID pipeline register layout.
package riscv_pkg;
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } ifid_t;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. bubble beats load; neither asserted means hold.
module ifid_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            bubble,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);
    ifid_t ifid_q, ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (bubble) begin
            ifid_d.valid    = 1'b0;
            ifid_d.instr    = NOP_INSTR;
            ifid_d.pc       = pc_in;
            ifid_d.pc_plus4 = pc_in + XLEN'(4);
        end else if (load) begin
            ifid_d.valid    = 1'b1;
            ifid_d.instr    = instr_in;
            ifid_d.pc       = pc_in;
            ifid_d.pc_plus4 = pc_in + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q.valid    <= 1'b0;
            ifid_q.instr    <= NOP_INSTR;
            ifid_q.pc       <= '0;
            ifid_q.pc_plus4 <= '0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign valid    = ifid_q.valid;
    assign instr    = ifid_q.instr;
    assign pc       = ifid_q.pc;
    assign pc_plus4 = ifid_q.pc_plus4;
endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC selection and the misaligned-redirect halt state.
// The fetched word is captured one cycle later by ifid_reg.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned IMEM_AW = 6
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               mem_busy,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_target,
    output logic [XLEN-1:0]    pc,
    output logic               ifid_valid,
    output logic [31:0]        ifid_instr,
    output logic [XLEN-1:0]    ifid_pc,
    output logic [XLEN-1:0]    ifid_pc_plus4,
    output logic               misalign_err
);
    logic [XLEN-1:0] pc_q, pc_d;
    fetch_state_e    state_q, state_d;
    logic            ifid_load, ifid_bubble;

    // Priority: halted > redirect > stall > mem_busy > normal fetch.
    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (state_q == FS_HALT) begin
            ifid_bubble = 1'b1;
        end else if (redirect_valid) begin
            ifid_bubble = 1'b1;
            if (redirect_target[1:0] == 2'b00) pc_d = redirect_target;
            else                               state_d = FS_HALT;
        end else if (stall) begin
            // hold everything, even if the memory port is also taken
        end else if (mem_busy) begin
            ifid_bubble = 1'b1;
        end else begin
            ifid_load = 1'b1;
            pc_d      = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= FS_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign pc           = pc_q;
    assign imem_addr    = pc_q[IMEM_AW+1:2];
    assign misalign_err = (state_q == FS_HALT);

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .instr_in (imem_rdata),
        .pc_in    (pc_q),
        .valid    (ifid_valid),
        .instr    (ifid_instr),
        .pc       (ifid_pc),
        .pc_plus4 (ifid_pc_plus4)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural model pushes expected next state per cycle,
// popped and compared one clock later.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        mem_busy, stall, redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4;
    logic        misalign_err;

    logic [31:0] mem [64];
    int total = 0;
    int bad = 0;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] pc;
        logic        merr;
    } exp_t;
    exp_t sb[$];
    exp_t m;

    always #5 clk = ~clk;
    assign imem_rdata = mem[imem_addr];

    fetch_stage #(.IMEM_AW(6)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .mem_busy(mem_busy), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .pc(pc), .ifid_valid(ifid_valid),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
        .misalign_err(misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle, predict, then compare after the edge.
    task automatic step(input logic r, input logic bsy, input logic stl,
                        input logic rv, input logic [31:0] tgt);
        exp_t e;
        exp_t o;
        rst = r; mem_busy = bsy; stall = stl;
        redirect_valid = rv; redirect_target = tgt;
        #1;
        chk("imem_addr", {26'd0, imem_addr}, {26'd0, m.pc[7:2]});
        e = m;
        if (r) begin
            e = '{v: 1'b0, instr: 32'h13, ipc: 0, ipc4: 0, pc: 0, merr: 1'b0};
        end else if (m.merr) begin
            e.v = 0; e.instr = 32'h13; e.ipc = m.pc; e.ipc4 = m.pc + 4;
        end else if (rv) begin
            e.v = 0; e.instr = 32'h13; e.ipc = m.pc; e.ipc4 = m.pc + 4;
            if (tgt[1:0] == 2'b00) e.pc = tgt;
            else e.merr = 1'b1;
        end else if (stl) begin
            e = m;
        end else if (bsy) begin
            e.v = 0; e.instr = 32'h13; e.ipc = m.pc; e.ipc4 = m.pc + 4;
        end else begin
            e.v = 1; e.instr = mem[m.pc[7:2]]; e.ipc = m.pc; e.ipc4 = m.pc + 4;
            e.pc = m.pc + 4;
        end
        sb.push_back(e);
        m = e;
        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, o.v});
        chk("ifid_instr", ifid_instr, o.instr);
        chk("ifid_pc", ifid_pc, o.ipc);
        chk("ifid_pc_plus4", ifid_pc_plus4, o.ipc4);
        chk("pc", pc, o.pc);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, o.merr});
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h0000_2083;
        mem[1] = 32'h0040_2103;
        mem[2] = 32'h0080_2183;
        m = '{v: 1'b0, instr: 32'h13, ipc: 0, ipc4: 0, pc: 0, merr: 1'b0};
        rst = 1; mem_busy = 0; stall = 0; redirect_valid = 0; redirect_target = 0;
        @(negedge clk);

        // reset wins over a simultaneous stall and redirect
        step(1, 1, 1, 1, 32'h40);
        chk("rst_pc", pc, 32'h0);
        free_run(3);
        chk("free_pc", pc, 32'hC);
        chk("free_ifid_pc", ifid_pc, 32'h8);

        // mem_busy bubble at pc=8
        step(1, 0, 0, 0, 0);
        free_run(2);
        step(0, 1, 0, 0, 0);
        chk("busy_valid", {31'd0, ifid_valid}, 32'd0);
        chk("busy_pc", pc, 32'h8);
        free_run(1);
        chk("busy_next_instr", ifid_instr, 32'h0080_2183);

        // stall holds, stall+mem_busy still holds
        step(1, 0, 0, 0, 0);
        free_run(2);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("stall_instr", ifid_instr, 32'h0040_2103);
        chk("stall_pc", pc, 32'h8);

        // redirect beats stall
        step(0, 0, 1, 1, 32'h18);
        chk("redir_addr", {26'd0, imem_addr}, 32'd6);
        free_run(1);
        chk("redir_ifid_pc4", ifid_pc_plus4, 32'h1C);

        // wrap at the top of the memory and of the address space
        step(0, 0, 0, 1, 32'hFC);
        chk("wrap_addr63", {26'd0, imem_addr}, 32'd63);
        free_run(2);
        chk("wrap_ifid_pc", ifid_pc, 32'h100);
        chk("wrap_instr", ifid_instr, 32'h0000_2083);
        step(0, 0, 0, 1, 32'hFFFF_FFFC);
        free_run(1);
        chk("pc_mod", pc, 32'h0);

        // misaligned redirect halts until reset
        free_run(1);
        step(0, 0, 0, 1, 32'h1A);
        for (int i = 0; i < 6; i++) step(0, i[0], 0, 1, 32'h20);
        chk("halt_err", {31'd0, misalign_err}, 32'd1);
        chk("halt_pc", pc, 32'h4);
        step(1, 0, 0, 1, 32'h1A);
        chk("halt_rst_err", {31'd0, misalign_err}, 32'd0);

        // random mix
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = $urandom_range(0, 127);
            if ($urandom_range(0, 15) != 0) t[1:0] = 2'b00;
            step($urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
